// File: rtl/fpu_pkg.sv
// Shared opcode encodings, result latencies and decode helpers for the FP issue stage.
package fpu_pkg;

  localparam int LAT_MISC = 1;
  localparam int LAT_ADD  = 2;
  localparam int LAT_DIV  = 3;
  localparam int NSLOT    = 4;
  localparam int SLOT_W   = $clog2(NSLOT);

  localparam logic [3:0] FOP_NOP   = 4'd0;
  localparam logic [3:0] FOP_FADD  = 4'd1;
  localparam logic [3:0] FOP_FSUB  = 4'd2;
  localparam logic [3:0] FOP_FMUL  = 4'd3;
  localparam logic [3:0] FOP_FDIV  = 4'd4;
  localparam logic [3:0] FOP_FSQRT = 4'd5;
  localparam logic [3:0] FOP_FEQ   = 4'd6;
  localparam logic [3:0] FOP_FLT   = 4'd7;
  localparam logic [3:0] FOP_FLE   = 4'd8;
  localparam logic [3:0] FOP_FTOI  = 4'd9;
  localparam logic [3:0] FOP_ITOF  = 4'd10;
  localparam logic [3:0] FOP_FNEG  = 4'd11;
  localparam logic [3:0] FOP_FLUP  = 4'd12;

  typedef struct packed {
    logic       occ;
    logic [5:0] addr;
  } slot_t;

  function automatic logic op_uses_rs(input logic [3:0] op);
    return (op >= FOP_FADD) && (op <= FOP_FNEG);
  endfunction

  function automatic logic op_uses_rt(input logic [3:0] op);
    case (op)
      FOP_FADD, FOP_FSUB, FOP_FMUL, FOP_FDIV,
      FOP_FEQ, FOP_FLT, FOP_FLE: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic [SLOT_W-1:0] op_latency(input logic [3:0] op);
    case (op)
      FOP_FADD, FOP_FSUB:  return SLOT_W'(LAT_ADD);
      FOP_FDIV, FOP_FSQRT: return SLOT_W'(LAT_DIV);
      default:             return SLOT_W'(LAT_MISC);
    endcase
  endfunction

endpackage

// File: rtl/fpu_scoreboard.sv
// Latency-slot scoreboard: slot[k] holds the register written back k cycles from now.
module fpu_scoreboard
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [5:0]        rs,
  input  logic [5:0]        rt,
  input  logic [5:0]        rd,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              set,
  input  logic [SLOT_W-1:0] lat,
  output logic              raw_hit,
  output logic              waw_hit,
  output logic [NSLOT-1:0]  slot_busy
);

  slot_t slot [1:NSLOT-1];

  // NOTE: the slot array is only a few flops and must read empty right after
  // reset, so it is reset like ordinary state; all updates are non-blocking so
  // the shift and the new-slot write see the same pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 1; k < NSLOT; k++) slot[k] <= '0;
    end else begin
      for (int k = 1; k < NSLOT - 1; k++) slot[k] <= slot[k+1];
      slot[NSLOT-1] <= '0;
      if (set && rd != 6'd0) slot[lat] <= '{occ: 1'b1, addr: rd};
    end
  end

  // NOTE: every output gets a default before the loops so no latch is inferred.
  always_comb begin
    raw_hit   = 1'b0;
    waw_hit   = 1'b0;
    slot_busy = '0;
    for (int k = 1; k < NSLOT; k++) begin
      if (slot[k].occ) begin
        if (use_rs && rs != 6'd0 && rs == slot[k].addr) raw_hit = 1'b1;
        if (use_rt && rt != 6'd0 && rt == slot[k].addr) raw_hit = 1'b1;
        if (rd != 6'd0 && rd == slot[k].addr)           waw_hit = 1'b1;
      end
    end
    // Occupancy as it will be after this cycle's shift.
    for (int k = 0; k < NSLOT - 1; k++) slot_busy[k] = slot[k+1].occ;
  end

endmodule

// File: rtl/fpu_issue.sv
// FP issue stage: hazard-checked accept, operand read with write-back bypass,
// one registered operation per cycle toward the FPU.
module fpu_issue
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_ctrl,
  input  logic [5:0]  in_rs,
  input  logic [5:0]  in_rt,
  input  logic [5:0]  in_rd,
  input  logic [15:0] in_imm,
  output logic [5:0]  rf_rs_addr,
  output logic [5:0]  rf_rt_addr,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] rf_rt_data,
  input  logic [5:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [3:0]  fpu_ctrl,
  output logic [31:0] fpu_ds_val,
  output logic [31:0] fpu_dt_val,
  output logic [5:0]  fpu_dd,
  output logic [15:0] fpu_imm,
  output logic        illegal,
  output logic [15:0] stall_cnt
);

  logic              legal, is_op, use_rs, use_rt, fire;
  logic              raw_hit, waw_hit;
  logic [NSLOT-1:0]  slot_busy;
  logic [SLOT_W-1:0] lat;
  logic [31:0]       ds_next, dt_next;

  assign rf_rs_addr = in_rs;
  assign rf_rt_addr = in_rt;

  assign legal  = in_ctrl <= FOP_FLUP;
  assign is_op  = legal && in_ctrl != FOP_NOP;
  assign use_rs = op_uses_rs(in_ctrl);
  assign use_rt = op_uses_rt(in_ctrl);
  assign lat    = op_latency(in_ctrl);

  // Nops and illegal opcodes never enter the scoreboard, so they never stall.
  assign in_ready = !is_op || !(raw_hit || waw_hit || slot_busy[lat]);
  assign fire     = in_valid && in_ready && is_op;

  // The register file does not yet hold the write-back landing this cycle.
  assign ds_next = !use_rs ? 32'd0 :
                   (in_rs != 6'd0 && in_rs == wb_addr) ? wb_data : rf_rs_data;
  assign dt_next = !use_rt ? 32'd0 :
                   (in_rt != 6'd0 && in_rt == wb_addr) ? wb_data : rf_rt_data;

  fpu_scoreboard u_scoreboard (
    .clk       (clk),
    .rstn      (rstn),
    .rs        (in_rs),
    .rt        (in_rt),
    .rd        (in_rd),
    .use_rs    (use_rs),
    .use_rt    (use_rt),
    .set       (fire),
    .lat       (lat),
    .raw_hit   (raw_hit),
    .waw_hit   (waw_hit),
    .slot_busy (slot_busy)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fpu_ctrl   <= '0;
      fpu_ds_val <= '0;
      fpu_dt_val <= '0;
      fpu_dd     <= '0;
      fpu_imm    <= '0;
      illegal    <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      illegal <= in_valid && !legal;
      if (in_valid && !in_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (fire) begin
        fpu_ctrl   <= in_ctrl;
        fpu_ds_val <= ds_next;
        fpu_dt_val <= dt_next;
        fpu_dd     <= in_rd;
        fpu_imm    <= in_imm;
      end else begin
        fpu_ctrl   <= '0;
        fpu_ds_val <= '0;
        fpu_dt_val <= '0;
        fpu_dd     <= '0;
      end
    end
  end

endmodule
